// File: rtl/nvdla_csb_ctrl.sv
// CSB command sequencer: issues a single read or write on the NVDLA CSB request channel and waits for its response.
// It can then wait for the NVDLA interrupt, and aborts with an error flag when a timeout expires.
module nvdla_csb_ctrl #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdat_i,
    input  logic        write_i,
    input  logic        wait_intr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        csb_valid_o,
    input  logic        csb_ready_i,
    output logic [15:0] csb_addr_o,
    output logic [31:0] csb_wdat_o,
    output logic        csb_write_o,
    output logic        csb_nposted_o,
    input  logic        csb_rvalid_i,
    input  logic [31:0] csb_rdata_i,
    input  logic        csb_wr_complete_i,
    input  logic        intr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CONSUME,
        S_WAIT_INTR,
        S_TERMINATE
    } state_t;

    // The counter starts at zero on state entry, so the abort fires on the TIMEOUT-th cycle in the state.
    localparam logic [31:0] CNT_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [15:0] r_addr;
    logic [31:0] r_wdat;
    logic        r_write;
    logic        r_wait;
    logic        r_pend;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_rdata;

    logic w_resp;
    logic w_timeout;

    assign w_resp    = r_write ? csb_wr_complete_i : csb_rvalid_i;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_write <= 1'b0;
            r_wait  <= 1'b0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (clear_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr  <= addr_i;
                        r_wdat  <= wdat_i;
                        r_write <= write_i;
                        r_wait  <= wait_intr_i;
                        r_err   <= 1'b0;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (intr_i) begin
                        r_pend <= 1'b1;
                    end
                    if (csb_ready_i) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_CONSUME;
                    end
                end
                S_CONSUME: begin
                    if (intr_i) begin
                        r_pend <= 1'b1;
                    end
                    // A response in the final counted cycle still wins over the timeout.
                    if (w_resp) begin
                        if (!r_write) begin
                            r_rdata <= csb_rdata_i;
                        end
                        r_cnt <= '0;
                        if (r_wait) begin
                            r_state <= S_WAIT_INTR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_TERMINATE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_TERMINATE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT_INTR: begin
                    if (intr_i || r_pend) begin
                        r_done  <= 1'b1;
                        r_state <= S_TERMINATE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_TERMINATE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_TERMINATE: begin
                    r_busy  <= 1'b0;
                    r_pend  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign rdata_o       = r_rdata;
    assign csb_valid_o   = r_valid;
    assign csb_addr_o    = r_addr;
    assign csb_wdat_o    = r_wdat;
    assign csb_write_o   = r_write;
    assign csb_nposted_o = r_write;

endmodule

// File: tb/tb_nvdla_csb_ctrl.sv
// Bench for nvdla_csb_ctrl: directed and random CSB commands compared against a cycle-timeline model.
// The model derives each command's completion cycle, error flag and read data from the per-command stimulus schedule.
module tb_nvdla_csb_ctrl;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [15:0] addr_i;
    logic [31:0] wdat_i;
    logic        write_i;
    logic        wait_intr_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        csb_valid_o;
    logic        csb_ready_i;
    logic [15:0] csb_addr_o;
    logic [31:0] csb_wdat_o;
    logic        csb_write_o;
    logic        csb_nposted_o;
    logic        csb_rvalid_i;
    logic [31:0] csb_rdata_i;
    logic        csb_wr_complete_i;
    logic        intr_i;

    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    logic [31:0] model_rdata = '0;

    nvdla_csb_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .start_i          (start_i),
        .addr_i           (addr_i),
        .wdat_i           (wdat_i),
        .write_i          (write_i),
        .wait_intr_i      (wait_intr_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .rdata_o          (rdata_o),
        .csb_valid_o      (csb_valid_o),
        .csb_ready_i      (csb_ready_i),
        .csb_addr_o       (csb_addr_o),
        .csb_wdat_o       (csb_wdat_o),
        .csb_write_o      (csb_write_o),
        .csb_nposted_o    (csb_nposted_o),
        .csb_rvalid_i     (csb_rvalid_i),
        .csb_rdata_i      (csb_rdata_i),
        .csb_wr_complete_i(csb_wr_complete_i),
        .intr_i           (intr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        clear_i           = 1'b0;
        start_i           = 1'b0;
        addr_i            = '0;
        wdat_i            = '0;
        write_i           = 1'b0;
        wait_intr_i       = 1'b0;
        csb_ready_i       = 1'b0;
        csb_rvalid_i      = 1'b0;
        csb_rdata_i       = '0;
        csb_wr_complete_i = 1'b0;
        intr_i            = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},    32'(busy_o),        32'd0);
        chk({tag, "_done"},    32'(done_o),        32'd0);
        chk({tag, "_err"},     32'(err_o),         32'd0);
        chk({tag, "_rdata"},   rdata_o,            32'd0);
        chk({tag, "_valid"},   32'(csb_valid_o),   32'd0);
        chk({tag, "_addr"},    32'(csb_addr_o),    32'd0);
        chk({tag, "_wdat"},    csb_wdat_o,         32'd0);
        chk({tag, "_write"},   32'(csb_write_o),   32'd0);
        chk({tag, "_nposted"}, 32'(csb_nposted_o), 32'd0);
    endtask

    // Called at the start of a cycle (just after a rising edge); returns at the start of the cycle after IDLE is re-entered.
    // Cycle 0 carries start_i; ready rises in cycle 1+d_r; response comes d_s cycles after entering CONSUME
    // (d_s >= TO means none); intr_i pulses in cycle ti (negative means never).
    task automatic run_txn(input bit wr, input bit wi, input logic [15:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int d_r, input int d_s, input int ti);
        int t_c, t_r, t_w, t_d;
        bit exp_err;
        logic [31:0] exp_rdata;
        int obs_done, done_cnt, busy_cnt, valid_cnt;
        bit req_ok, fin_err;
        logic [31:0] fin_rdata;

        t_c       = 2 + d_r;
        t_r       = t_c + d_s;
        t_w       = t_r + 1;
        exp_err   = 1'b0;
        exp_rdata = model_rdata;
        if (d_s >= TO) begin
            t_d     = t_c + TO;
            exp_err = 1'b1;
        end else begin
            if (!wr) exp_rdata = rd;
            if (!wi) t_d = t_r + 1;
            else if (ti >= 1 && ti <= t_r) t_d = t_w + 1;
            else if (ti >= t_w && (ti - t_w) < TO) t_d = ti + 1;
            else begin
                t_d     = t_w + TO;
                exp_err = 1'b1;
            end
        end

        obs_done = -1; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        req_ok = 1'b1; fin_err = 1'b0; fin_rdata = '0;
        for (int n = 0; n <= t_d + 1; n++) begin
            if (n == 0) begin
                start_i = 1'b1; addr_i = a; wdat_i = wd; write_i = wr; wait_intr_i = wi;
            end else begin
                start_i     = (n <= t_d) && ($urandom_range(0, 3) == 0);
                addr_i      = 16'($urandom);
                wdat_i      = $urandom;
                write_i     = 1'($urandom);
                wait_intr_i = 1'($urandom);
            end
            csb_ready_i = (n == 1 + d_r);
            intr_i      = (n == ti);
            csb_rdata_i = $urandom;
            if (wr) begin
                csb_wr_complete_i = (d_s < TO) && (n == t_r);
                csb_rvalid_i      = 1'($urandom);
            end else begin
                csb_wr_complete_i = 1'($urandom);
                if ((d_s < TO) && (n == t_r)) begin
                    csb_rvalid_i = 1'b1;
                    csb_rdata_i  = rd;
                end else begin
                    csb_rvalid_i = (n >= 1 && n < t_c) ? 1'($urandom) : 1'b0;
                end
            end
            @(negedge clk_i);
            if (done_o) begin
                done_cnt++;
                obs_done = n;
            end
            busy_cnt += int'(busy_o);
            if (csb_valid_o) begin
                valid_cnt++;
                if (csb_addr_o !== a || csb_wdat_o !== wd || csb_write_o !== wr || csb_nposted_o !== wr)
                    req_ok = 1'b0;
            end
            if (n == t_d + 1) begin
                fin_err   = err_o;
                fin_rdata = rdata_o;
            end
            @(posedge clk_i);
            #1;
        end
        idle_inputs();

        chk("done_cycle", 32'(obs_done),  32'(t_d));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("valid_cycles", 32'(valid_cnt), 32'(d_r + 1));
        chk("req_fields", 32'(req_ok), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(t_d));
        chk("err", 32'(fin_err), 32'(exp_err));
        chk("rdata", fin_rdata, exp_rdata);
        model_rdata = exp_rdata;
        $display("txn %0d wr=%0d wi=%0d addr=%04h d_r=%0d d_s=%0d ti=%0d done@%0d exp@%0d err=%0d rdata=%08h",
                 txn_id, wr, wi, a, d_r, d_s, ti, obs_done, t_d, fin_err, fin_rdata);
        txn_id++;
    endtask

    initial begin
        int done_seen;
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Read with ready held low for 3 cycles.
        run_txn(1'b0, 1'b0, 16'h0004, 32'h0, 32'hDEADBEEF, 3, 0, -1);
        // Write waiting for an interrupt 10 cycles after write completion.
        run_txn(1'b1, 1'b1, 16'h0010, 32'h12345678, 32'h0, 0, 2, 14);
        // Interrupt arrives during START and must be remembered.
        run_txn(1'b1, 1'b1, 16'h0020, 32'hA5A5A5A5, 32'h0, 0, 1, 1);
        // Minimum latency read.
        run_txn(1'b0, 1'b0, 16'h0030, 32'h0, 32'h0BADF00D, 0, 0, -1);
        // Read with no response times out; the next command clears err_o.
        run_txn(1'b0, 1'b0, 16'h0040, 32'h0, 32'h11111111, 1, TO, -1);
        run_txn(1'b0, 1'b0, 16'h0044, 32'h0, 32'hCAFEF00D, 0, 0, -1);
        // Response in the last cycle before the timeout, then an interrupt-wait timeout.
        run_txn(1'b0, 1'b0, 16'h0048, 32'h0, 32'h76543210, 0, TO - 1, -1);
        run_txn(1'b1, 1'b1, 16'h004C, 32'h01020304, 32'h0, 2, 0, -1);

        // clear_i during CONSUME, together with a start_i that must lose.
        start_i = 1'b1; addr_i = 16'h0050; write_i = 1'b0; wait_intr_i = 1'b0;
        @(negedge clk_i); @(posedge clk_i); #1;
        start_i = 1'b0; csb_ready_i = 1'b1;
        @(negedge clk_i); @(posedge clk_i); #1;
        csb_ready_i = 1'b0; clear_i = 1'b1; start_i = 1'b1; addr_i = 16'h0054;
        @(negedge clk_i);
        chk("clear_busy_before", 32'(busy_o), 32'd1);
        @(posedge clk_i); #1;
        idle_inputs();
        done_seen = 0;
        @(negedge clk_i);
        chk("clear_busy", 32'(busy_o), 32'd0);
        chk("clear_valid", 32'(csb_valid_o), 32'd0);
        chk("clear_rdata", rdata_o, 32'd0);
        chk("clear_err", 32'(err_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            done_seen += int'(done_o) + int'(busy_o);
            @(negedge clk_i);
        end
        chk("clear_no_done_no_busy", 32'(done_seen), 32'd0);
        model_rdata = '0;
        @(posedge clk_i); #1;

        // Populate rdata, then reset asynchronously while in START.
        run_txn(1'b0, 1'b0, 16'h0060, 32'h0, 32'h55AA55AA, 0, 0, -1);
        start_i = 1'b1; addr_i = 16'h0064; wdat_i = 32'h89ABCDEF; write_i = 1'b1; wait_intr_i = 1'b1;
        @(negedge clk_i); @(posedge clk_i); #1;
        idle_inputs();
        #2;
        chk("rst_pre_valid", 32'(csb_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            done_seen += int'(done_o) + int'(busy_o);
        end
        chk("rst_no_done_no_busy", 32'(done_seen), 32'd0);
        model_rdata = '0;
        @(posedge clk_i); #1;

        for (int r = 0; r < 40; r++) begin
            bit wr, wi;
            int d_r, d_s, pick, t_r, sel, ti;
            wr   = 1'($urandom);
            wi   = 1'($urandom);
            d_r  = $urandom_range(0, 4);
            pick = $urandom_range(0, 9);
            d_s  = (pick < 7) ? $urandom_range(0, 5) : ((pick == 7) ? TO - 1 : TO);
            t_r  = 2 + d_r + d_s;
            sel  = $urandom_range(0, 3);
            if (sel == 0) ti = -1;
            else if (sel == 1) ti = $urandom_range(1, t_r);
            else ti = t_r + $urandom_range(1, TO + 2);
            run_txn(wr, wi, 16'($urandom), $urandom, $urandom, d_r, d_s, ti);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvdla_csb_ctrl.md
NVDLA_CSB_CTRL -- requirements
Module: nvdla_csb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 65535: max cycles in CONSUME or WAIT_INTR before abort; 0 disables timeout.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clear_i  in  1  synchronous soft clear.
REQ-005 SHALL have port start_i  in  1  one-cycle command start pulse.
REQ-006 SHALL have ports addr_i  in  16, wdat_i  in  32, write_i  in  1, wait_intr_i  in  1: CSB command fields.
REQ-007 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-008 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-009 SHALL have port err_o  out  1  timeout flag of the last command.
REQ-010 SHALL have port rdata_o  out  32  read data of the last read.
REQ-011 SHALL have ports csb_valid_o  out  1, csb_ready_i  in  1, csb_addr_o  out  16, csb_wdat_o  out  32, csb_write_o  out  1, csb_nposted_o  out  1: request channel to NVDLA.
REQ-012 SHALL have ports csb_rvalid_i  in  1, csb_rdata_i  in  32, csb_wr_complete_i  in  1: response channel from NVDLA.
REQ-013 SHALL have port intr_i  in  1  NVDLA interrupt, level.

Function
REQ-014 SHALL implement states IDLE, START, CONSUME, WAIT_INTR, TERMINATE.
REQ-015 SHALL, in IDLE with start_i=1, register addr/wdat/write/wait_intr, clear err_o and pending-interrupt flag, and go to START next cycle.
REQ-016 SHALL ignore start_i in any state other than IDLE.
REQ-017 SHALL drive csb_valid_o=1 only in START, with csb_addr_o/csb_wdat_o/csb_write_o from registered fields and csb_nposted_o=1 for writes, 0 for reads.
REQ-018 SHALL hold START and all request outputs stable until csb_ready_i=1; on valid&ready go to CONSUME next cycle.
REQ-019 SHALL, in CONSUME for a read, wait for csb_rvalid_i=1, capture csb_rdata_i into rdata_o that cycle.
REQ-020 SHALL, in CONSUME for a write, wait for csb_wr_complete_i=1.
REQ-021 SHALL, on response, go to WAIT_INTR if wait_intr set, else TERMINATE.
REQ-022 SHALL latch intr_i=1 into a pending flag in any of START/CONSUME/WAIT_INTR, so an interrupt arriving before WAIT_INTR is not lost.
REQ-023 SHALL leave WAIT_INTR to TERMINATE in the cycle after intr_i=1 or pending flag is set.
REQ-024 SHALL assert done_o=1 for exactly the one TERMINATE cycle, then return to IDLE.
REQ-025 SHALL count cycles in CONSUME and WAIT_INTR (16+ bit counter, reset on state entry); when count reaches TIMEOUT (TIMEOUT>0) go to TERMINATE with err_o=1.
REQ-026 SHALL ignore csb_rvalid_i/csb_wr_complete_i outside CONSUME; rdata_o unchanged for writes.
REQ-027 SHALL hold err_o and rdata_o until next accepted start_i, clear_i or reset.
REQ-028 SHALL, on clear_i=1 in any state, go to IDLE next cycle, drop csb_valid_o, zero rdata_o/err_o/pending flag, no done_o; clear_i wins over simultaneous start_i.
REQ-029 SHALL make minimum latency start_i to done_o 3 cycles (ready and response in same-cycle-as-possible, no wait_intr).

Reset
REQ-030 SHALL, on rst_i=1, immediately go to IDLE: busy_o=0, done_o=0, err_o=0, rdata_o=0, csb_valid_o=0, csb_addr_o=0, csb_wdat_o=0, csb_write_o=0, csb_nposted_o=0, counter and pending flag 0.
REQ-031 SHALL abort any in-flight command on reset without done_o.

Verification
REQ-032 Read: start addr=0x0004, write=0, ready held 0 for 3 cycles -> csb_valid_o stable 4 cycles; rvalid with 0xDEADBEEF -> rdata_o=0xDEADBEEF, done_o one pulse, err_o=0.
REQ-033 Write with wait_intr=1: wdat=0x12345678, wr_complete after 2 cycles, intr_i after 10 more -> csb_nposted_o=1, done_o one cycle after intr_i.
REQ-034 Early interrupt: intr_i pulse during START, wait_intr=1 -> WAIT_INTR exits after one cycle, done_o asserted.
REQ-035 Timeout: TIMEOUT=8, read, no rvalid -> done_o at ~8 cycles after CONSUME entry, err_o=1; next start clears err_o.
REQ-036 Clear/reset mid-op: clear_i in CONSUME -> IDLE, no done_o, rdata_o=0; rst_i in START -> csb_valid_o=0 immediately, all outputs at reset values; start_i while busy ignored.
